// File: rtl/masc_wb_exec_pkg.sv
// rtl/masc_wb_exec_pkg.sv - register map, CTRL bit positions and sequencer state for masc_wb_exec_regs
package masc_wb_exec_pkg;

  localparam int RES_W = 33;

  localparam logic [7:0] OFF_RS1    = 8'h00;
  localparam logic [7:0] OFF_RS2    = 8'h04;
  localparam logic [7:0] OFF_INSN   = 8'h08;
  localparam logic [7:0] OFF_CTRL   = 8'h0C;
  localparam logic [7:0] OFF_RES_LO = 8'h10;
  localparam logic [7:0] OFF_RES_HI = 8'h14;

  // Write-side and read-side meanings share bit positions.
  localparam int CTRL_START    = 0;
  localparam int CTRL_BUSY     = 0;
  localparam int CTRL_IRQ_EN   = 1;
  localparam int CTRL_DONE_CLR = 2;
  localparam int CTRL_DONE     = 2;

  typedef enum logic {
    IDLE = 1'b0,
    WAIT = 1'b1
  } seq_state_e;

  function automatic logic [31:0] byte_merge(input logic [31:0] old_v,
                                             input logic [31:0] new_v,
                                             input logic [3:0]  sel);
    logic [31:0] r;
    r = old_v;
    for (int i = 0; i < 4; i++) begin
      if (sel[i]) r[8*i +: 8] = new_v[8*i +: 8];
    end
    return r;
  endfunction

endpackage

// File: rtl/masc_exec_seq.sv
// rtl/masc_exec_seq.sv - launch/latency sequencer with result capture and DONE flag
module masc_exec_seq
  import masc_wb_exec_pkg::*;
#(
  parameter int EXEC_LATENCY = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start_i,
  input  logic             done_clr_i,
  input  logic [RES_W-1:0] exec_out_i,
  output logic             busy_o,
  output logic             done_o,
  output logic             done_nxt_o,
  output logic [RES_W-1:0] res_o
);

  localparam logic [3:0] CNT_LOAD = 4'(EXEC_LATENCY - 1);

  seq_state_e       state_q, state_d;
  logic [3:0]       cnt_q, cnt_d;
  logic             done_q, done_d;
  logic [RES_W-1:0] res_q, res_d;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    done_d  = done_q;
    res_d   = res_q;
    if (done_clr_i) done_d = 1'b0;
    case (state_q)
      IDLE: begin
        if (start_i) begin
          state_d = WAIT;
          cnt_d   = CNT_LOAD;
          done_d  = 1'b0;
        end
      end
      WAIT: begin
        // Capture overrides a same-cycle DONE_CLR.
        if (cnt_q == 4'd0) begin
          res_d   = exec_out_i;
          done_d  = 1'b1;
          state_d = IDLE;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= 4'd0;
      done_q  <= 1'b0;
      res_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      done_q  <= done_d;
      res_q   <= res_d;
    end
  end

  assign busy_o     = (state_q == WAIT);
  assign done_o     = done_q;
  assign done_nxt_o = done_d;
  assign res_o      = res_q;

endmodule

// File: rtl/masc_wb_exec_regs.sv
// rtl/masc_wb_exec_regs.sv - Wishbone register front end driving the masc execute unit
module masc_wb_exec_regs
  import masc_wb_exec_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR    = 32'h3000_0000,
  parameter int          EXEC_LATENCY = 2
) (
  input  logic             wb_clk_i,
  input  logic             wb_rst_i,
  input  logic             wbs_stb_i,
  input  logic             wbs_cyc_i,
  input  logic             wbs_we_i,
  input  logic [3:0]       wbs_sel_i,
  input  logic [31:0]      wbs_adr_i,
  input  logic [31:0]      wbs_dat_i,
  output logic             wbs_ack_o,
  output logic [31:0]      wbs_dat_o,
  output logic [31:0]      exec_insn_o,
  output logic [31:0]      exec_rs1_o,
  output logic [31:0]      exec_rs2_o,
  input  logic [RES_W-1:0] exec_out_i,
  output logic             irq_o
);

  logic             ack_q, ack_d;
  logic [31:0]      dat_q, dat_d;
  logic [31:0]      rs1_q, rs1_d, rs2_q, rs2_d, insn_q, insn_d;
  logic             irq_en_q, irq_en_d;
  logic             irq_q, irq_d;

  logic             hit, acc, wr, rd, ctrl_wr, reg_wr_ok;
  logic [7:0]       off;
  logic             start, done_clr;
  logic             busy, done, done_nxt;
  logic [RES_W-1:0] res;
  logic [31:0]      rdata;

  assign hit       = (wbs_adr_i[31:8] == BASE_ADDR[31:8]);
  assign acc       = wbs_cyc_i & wbs_stb_i & hit & ~ack_q;
  assign wr        = acc & wbs_we_i;
  assign rd        = acc & ~wbs_we_i;
  assign off       = wbs_adr_i[7:0];
  assign ctrl_wr   = wr & (off == OFF_CTRL) & wbs_sel_i[0];
  assign start     = ctrl_wr & wbs_dat_i[CTRL_START];
  assign done_clr  = ctrl_wr & wbs_dat_i[CTRL_DONE_CLR];
  // Operands are frozen while an operation is in flight.
  assign reg_wr_ok = wr & ~busy;

  masc_exec_seq #(
    .EXEC_LATENCY(EXEC_LATENCY)
  ) u_seq (
    .clk        (wb_clk_i),
    .rst        (wb_rst_i),
    .start_i    (start),
    .done_clr_i (done_clr),
    .exec_out_i (exec_out_i),
    .busy_o     (busy),
    .done_o     (done),
    .done_nxt_o (done_nxt),
    .res_o      (res)
  );

  always_comb begin
    rs1_d    = rs1_q;
    rs2_d    = rs2_q;
    insn_d   = insn_q;
    irq_en_d = irq_en_q;
    if (reg_wr_ok && off == OFF_RS1)  rs1_d  = byte_merge(rs1_q, wbs_dat_i, wbs_sel_i);
    if (reg_wr_ok && off == OFF_RS2)  rs2_d  = byte_merge(rs2_q, wbs_dat_i, wbs_sel_i);
    if (reg_wr_ok && off == OFF_INSN) insn_d = byte_merge(insn_q, wbs_dat_i, wbs_sel_i);
    if (ctrl_wr) irq_en_d = wbs_dat_i[CTRL_IRQ_EN];
  end

  always_comb begin
    rdata = 32'd0;
    case (off)
      OFF_RS1:    rdata = rs1_q;
      OFF_RS2:    rdata = rs2_q;
      OFF_INSN:   rdata = insn_q;
      OFF_CTRL:   rdata = {29'd0, done, irq_en_q, busy};
      OFF_RES_LO: rdata = res[31:0];
      OFF_RES_HI: rdata = {31'd0, res[RES_W-1]};
      default:    rdata = 32'd0;
    endcase
  end

  // Registered from next-state so irq_o moves on the same edge as DONE/IRQ_EN.
  always_comb begin
    ack_d = acc;
    dat_d = rd ? rdata : 32'd0;
    irq_d = done_nxt & irq_en_d;
  end

  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      ack_q    <= 1'b0;
      dat_q    <= 32'd0;
      rs1_q    <= 32'd0;
      rs2_q    <= 32'd0;
      insn_q   <= 32'd0;
      irq_en_q <= 1'b0;
      irq_q    <= 1'b0;
    end else begin
      ack_q    <= ack_d;
      dat_q    <= dat_d;
      rs1_q    <= rs1_d;
      rs2_q    <= rs2_d;
      insn_q   <= insn_d;
      irq_en_q <= irq_en_d;
      irq_q    <= irq_d;
    end
  end

  assign wbs_ack_o   = ack_q;
  assign wbs_dat_o   = dat_q;
  assign exec_rs1_o  = rs1_q;
  assign exec_rs2_o  = rs2_q;
  assign exec_insn_o = insn_q;
  assign irq_o       = irq_q;

endmodule

// File: doc/masc_wb_exec_regs.md
# masc_wb_exec_regs

Wishbone responder that lets the management SoC drive the `__masc__execute` unit through memory-mapped registers instead of the logic analyzer. It holds the operand and instruction registers, launches an operation, and waits a fixed execute latency. It then captures the 33-bit result, reports done/busy status and raises an optional interrupt. It sits inside `user_proj_example` between the WB MI A slave port and `__masc__execute`.

## Interface
- `BASE_ADDR`, 32'h3000_0000: block base; decode compares `wbs_adr_i[31:8]` with `BASE_ADDR[31:8]`.
- `EXEC_LATENCY`, 2: cycles from operand launch to a valid `exec_out_i`; legal range 1..15.

Ports:
- `wb_clk_i` input 1: the one clock.
- `wb_rst_i` input 1: asynchronous, active-high reset.
- `wbs_stb_i`, `wbs_cyc_i`, `wbs_we_i` input 1 each: Wishbone classic strobe, cycle and write-enable.
- `wbs_sel_i` input 4: byte lane selects.
- `wbs_adr_i` input 32: byte address.
- `wbs_dat_i` input 32: write data.
- `wbs_ack_o` output 1: single-cycle acknowledge.
- `wbs_dat_o` output 32: registered read data.
- `exec_insn_o` output 32: instruction to the execute unit.
- `exec_rs1_o` output 32: rs1 operand to the execute unit.
- `exec_rs2_o` output 32: rs2 operand to the execute unit.
- `exec_out_i` input 33: execute unit result.
- `irq_o` output 1: interrupt, level equal to `done & irq_en`.

## Operation
- Register map (offsets from base):
  - 0x00 RS1, RW.
  - 0x04 RS2, RW.
  - 0x08 INSN, RW.
  - 0x0C CTRL:
    - Write: bit0 START (self-clearing), bit1 IRQ_EN, bit2 DONE_CLR (write 1 to clear).
    - Read: bit0 BUSY, bit1 IRQ_EN, bit2 DONE.
  - 0x10 RES_LO, RO: captured `out[31:0]`.
  - 0x14 RES_HI, RO: bit0 is captured `out[32]`, all other bits 0.
- `wbs_sel_i` masks writes on RS1, RS2 and INSN per byte. CTRL bits use lane 0 only.
- Unmapped offset inside the 256-byte window: acked, reads 0, write dropped.
- Address outside the window: never acked.
- `exec_*_o` are driven continuously from the RS1, RS2 and INSN registers.
- Writes to RS1, RS2 or INSN while BUSY are acked and dropped, so operands stay stable during an operation.
- Sequencer FSM:
  - IDLE: START write → WAIT; counter loaded with EXEC_LATENCY-1; DONE cleared.
  - WAIT: counter decrements each cycle. At 0, `exec_out_i` is captured into RES, DONE is set and the FSM → IDLE.
  - START while BUSY: ignored.
- BUSY = (state == WAIT).
- Simultaneous capture and DONE_CLR in the same cycle: set wins, DONE stays 1.
- START written while DONE=1: clears DONE and begins a new operation.
- Reset mid-operation: the operation is aborted and all state returns to reset values. No result is captured.

## Timing
- Reset values: `wbs_ack_o`=0, `wbs_dat_o`=0, `irq_o`=0, all registers 0, FSM in IDLE.
- Handshake:
  - `wbs_ack_o` rises on the edge after `cyc & stb & decode & !ack` is seen and stays high exactly one cycle.
  - Each access therefore takes 2 cycles. The master must deassert `stb` after ack; back-to-back accesses are separated by the ack cycle.
- Write commit: the register updates on the same edge that raises ack.
- Read data: `wbs_dat_o` is valid while ack is high; it is 0 when ack is low.
- Latency from the START-commit edge:
  - BUSY reads 1 on any access issued after the commit.
  - Capture happens EXEC_LATENCY edges later; DONE and `irq_o` rise on that edge.
- `irq_o` is registered and derived from the DONE and IRQ_EN flops. It has no combinational path from the Wishbone inputs.

## Structure
- Package `masc_wb_exec_pkg` holds:
  - Register offset constants.
  - CTRL bit-position constants.
  - The FSM state enum (IDLE, WAIT).
  - `RES_W` = 33.
- Sub-module `masc_exec_seq` contains the FSM, latency counter, result capture register and DONE flag.
- The top level contains Wishbone decode, the ack generator, the register file and the read mux.

## Test plan
- Reset then read every offset → all read 0, `irq_o`=0.
- Write RS1=0x0000_0005, RS2=0x0000_0003, INSN=ADD encoding, CTRL=0x3, with the execute model returning 33'h0_0000_0008 → BUSY=1 for EXEC_LATENCY cycles, then RES_LO=0x8, RES_HI=0, DONE=1, `irq_o`=1. Write CTRL=0x6 → DONE=0, `irq_o`=0.
- Write RS1=0xAABBCCDD with sel=4'b0101 over a prior value of 0 → RS1 reads 0x00BB00DD.
- Write RS1=0x1234 while BUSY → RS1 and `exec_rs1_o` unchanged. A second START while BUSY does not extend the operation.
- Assert `wb_rst_i` mid-WAIT → BUSY=0, DONE=0, RES=0 immediately; a fresh START still completes normally.
- Access offset 0x40 → acked with data 0. Access address 0x3000_1000 → no ack for 8 cycles.
